// File: rtl/frame_depadder_checker.sv
// Receive-side deframer: locks on SFD, validates LEN, forwards payload, strips and checks the
// zero pad, verifies the XOR checksum and keeps saturating good/bad frame counters.
module frame_depadder_checker #(
  parameter logic [7:0]  SFD      = 8'hD5,
  parameter int unsigned MIN_BODY = 16,
  parameter int unsigned MAX_LEN  = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  frame_data,
  input  logic        valid,
  output logic [7:0]  payload_data,
  output logic        payload_valid,
  output logic        payload_last,
  output logic        frame_done,
  output logic        frame_ok,
  output logic        err_len,
  output logic        err_pad,
  output logic        err_chk,
  output logic [15:0] good_count,
  output logic [15:0] bad_count
);

  typedef enum logic [2:0] {StIdle, StLen, StPayload, StPad, StChk} state_e;

  state_e      r_state, w_state;
  logic [7:0]  r_len, w_len;
  logic [7:0]  r_cnt, w_cnt;
  logic [7:0]  r_xor, w_xor;
  logic        r_pad_err, w_pad_err;
  logic [7:0]  r_pdata, w_pdata;
  logic        r_pvalid, w_pvalid;
  logic        r_plast, w_plast;
  logic        r_done, w_done;
  logic        r_ok, w_ok;
  logic        r_err_len, w_err_len;
  logic        r_err_pad, w_err_pad;
  logic        r_err_chk, w_err_chk;
  logic [15:0] r_good, w_good;
  logic [15:0] r_bad, w_bad;
  logic [7:0]  w_cnt_inc;

  assign w_cnt_inc = r_cnt + 8'd1;

  always_comb begin
    w_state   = r_state;
    w_len     = r_len;
    w_cnt     = r_cnt;
    w_xor     = r_xor;
    w_pad_err = r_pad_err;
    w_pdata   = r_pdata;
    w_pvalid  = 1'b0;
    w_plast   = 1'b0;
    w_done    = 1'b0;
    w_ok      = r_ok;
    w_err_len = r_err_len;
    w_err_pad = r_err_pad;
    w_err_chk = r_err_chk;
    w_good    = r_good;
    w_bad     = r_bad;

    if (valid) begin
      case (r_state)
        StIdle: begin
          if (frame_data == SFD) begin
            w_state   = StLen;
            w_xor     = 8'h00;
            w_pad_err = 1'b0;
            w_cnt     = 8'h00;
          end
        end
        StLen: begin
          if (frame_data == 8'h00 || frame_data > 8'(MAX_LEN)) begin
            w_state   = StIdle;
            w_done    = 1'b1;
            w_ok      = 1'b0;
            w_err_len = 1'b1;
            w_err_pad = 1'b0;
            w_err_chk = 1'b0;
          end else begin
            w_len   = frame_data;
            w_xor   = frame_data;
            w_state = StPayload;
          end
        end
        StPayload: begin
          w_pdata  = frame_data;
          w_pvalid = 1'b1;
          w_xor    = r_xor ^ frame_data;
          w_cnt    = w_cnt_inc;
          if (w_cnt_inc == r_len) begin
            w_plast = 1'b1;
            w_state = (r_len < 8'(MIN_BODY)) ? StPad : StChk;
          end
        end
        StPad: begin
          // Pad bytes keep counting toward MIN_BODY even after an error is seen.
          w_xor = r_xor ^ frame_data;
          w_cnt = w_cnt_inc;
          if (frame_data != 8'h00) w_pad_err = 1'b1;
          if (w_cnt_inc == 8'(MIN_BODY)) w_state = StChk;
        end
        StChk: begin
          w_state   = StIdle;
          w_done    = 1'b1;
          w_err_len = 1'b0;
          w_err_pad = r_pad_err;
          w_err_chk = (frame_data != r_xor);
          w_ok      = !r_pad_err && (frame_data == r_xor);
        end
        default: w_state = StIdle;
      endcase
    end

    if (w_done) begin
      if (w_ok) begin
        if (r_good != 16'hFFFF) w_good = r_good + 16'd1;
      end else begin
        if (r_bad != 16'hFFFF) w_bad = r_bad + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= StIdle;
      r_len     <= 8'h00;
      r_cnt     <= 8'h00;
      r_xor     <= 8'h00;
      r_pad_err <= 1'b0;
      r_pdata   <= 8'h00;
      r_pvalid  <= 1'b0;
      r_plast   <= 1'b0;
      r_done    <= 1'b0;
      r_ok      <= 1'b0;
      r_err_len <= 1'b0;
      r_err_pad <= 1'b0;
      r_err_chk <= 1'b0;
      r_good    <= 16'h0000;
      r_bad     <= 16'h0000;
    end else begin
      r_state   <= w_state;
      r_len     <= w_len;
      r_cnt     <= w_cnt;
      r_xor     <= w_xor;
      r_pad_err <= w_pad_err;
      r_pdata   <= w_pdata;
      r_pvalid  <= w_pvalid;
      r_plast   <= w_plast;
      r_done    <= w_done;
      r_ok      <= w_ok;
      r_err_len <= w_err_len;
      r_err_pad <= w_err_pad;
      r_err_chk <= w_err_chk;
      r_good    <= w_good;
      r_bad     <= w_bad;
    end
  end

  assign payload_data  = r_pdata;
  assign payload_valid = r_pvalid;
  assign payload_last  = r_plast;
  assign frame_done    = r_done;
  assign frame_ok      = r_ok;
  assign err_len       = r_err_len;
  assign err_pad       = r_err_pad;
  assign err_chk       = r_err_chk;
  assign good_count    = r_good;
  assign bad_count     = r_bad;

endmodule

// File: tb/tb_frame_depadder_checker.sv
// Bench for frame_depadder_checker: frames are built as tagged byte lists whose expected
// payload and verdict come from the framing rules; each accepted byte is checked one cycle later.
module tb_frame_depadder_checker;

  localparam logic [7:0] SFD = 8'hD5;
  localparam int MIN_BODY = 16;
  localparam int MAX_LEN  = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  frame_data;
  logic        valid;
  logic [7:0]  payload_data;
  logic        payload_valid, payload_last, frame_done, frame_ok;
  logic        err_len, err_pad, err_chk;
  logic [15:0] good_count, bad_count;

  always #5 clk = ~clk;

  frame_depadder_checker dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .frame_data   (frame_data),
    .valid        (valid),
    .payload_data (payload_data),
    .payload_valid(payload_valid),
    .payload_last (payload_last),
    .frame_done   (frame_done),
    .frame_ok     (frame_ok),
    .err_len      (err_len),
    .err_pad      (err_pad),
    .err_chk      (err_chk),
    .good_count   (good_count),
    .bad_count    (bad_count)
  );

  // One byte of the stream plus what it must cause once accepted.
  typedef struct packed {
    logic [7:0] b;
    logic       pay;
    logic       last;
    logic       done;
    logic       ok;
    logic       el;
    logic       ep;
    logic       ec;
  } item_t;

  item_t      q[$];
  logic [7:0] fixed_pl[$];
  int         n_checks = 0;
  int         n_errors = 0;

  // Reference view of the held verdict and the frame tallies.
  logic m_ok, m_el, m_ep, m_ec;
  int   m_good, m_bad;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] rand_not_sfd();
    logic [7:0] b;
    b = 8'($urandom);
    if (b == SFD) b = 8'h00;
    return b;
  endfunction

  task automatic push_junk(input int n);
    item_t it;
    for (int i = 0; i < n; i++) begin
      it = '0;
      it.b = rand_not_sfd();
      q.push_back(it);
    end
  endtask

  // Checksum is the XOR of LEN, payload and pad; chk_xor corrupts it, pad_idx/pad_val corrupt the pad.
  task automatic build_frame(input int len, input logic [7:0] chk_xor, input int pad_idx,
                             input logic [7:0] pad_val);
    item_t      it;
    logic [7:0] x;
    logic [7:0] pb;
    int         npad;
    logic       pad_bad;
    it = '0;
    it.b = SFD;
    q.push_back(it);
    it = '0;
    it.b = len[7:0];
    if (len < 1 || len > MAX_LEN) begin
      it.done = 1'b1;
      it.el   = 1'b1;
      q.push_back(it);
      fixed_pl.delete();
      return;
    end
    q.push_back(it);
    x = len[7:0];
    for (int i = 0; i < len; i++) begin
      it = '0;
      it.b    = (fixed_pl.size() == len) ? fixed_pl[i] : 8'($urandom);
      it.pay  = 1'b1;
      it.last = (i == len - 1);
      x ^= it.b;
      q.push_back(it);
    end
    npad    = (len < MIN_BODY) ? MIN_BODY - len : 0;
    pad_bad = 1'b0;
    for (int i = 0; i < npad; i++) begin
      pb = (i == pad_idx) ? pad_val : 8'h00;
      if (pb != 8'h00) pad_bad = 1'b1;
      it = '0;
      it.b = pb;
      x ^= pb;
      q.push_back(it);
    end
    it = '0;
    it.b    = x ^ chk_xor;
    it.done = 1'b1;
    it.ep   = pad_bad;
    it.ec   = (chk_xor != 8'h00);
    it.ok   = !pad_bad && (chk_xor == 8'h00);
    q.push_back(it);
    fixed_pl.delete();
  endtask

  task automatic step(input logic v, input logic [7:0] d, input item_t it);
    logic exp_pv, exp_done;
    frame_data = d;
    valid      = v;
    @(posedge clk);
    @(negedge clk);
    exp_pv   = v && it.pay;
    exp_done = v && it.done;
    if (exp_done) begin
      m_ok = it.ok;
      m_el = it.el;
      m_ep = it.ep;
      m_ec = it.ec;
      if (it.ok) m_good = (m_good < 65535) ? m_good + 1 : m_good;
      else       m_bad  = (m_bad  < 65535) ? m_bad  + 1 : m_bad;
    end
    check_eq("payload_valid", 32'(payload_valid), 32'(exp_pv));
    if (exp_pv) begin
      check_eq("payload_data", 32'(payload_data), 32'(it.b));
      check_eq("payload_last", 32'(payload_last), 32'(it.last));
    end
    check_eq("frame_done", 32'(frame_done), 32'(exp_done));
    check_eq("frame_ok", 32'(frame_ok), 32'(m_ok));
    check_eq("err_len", 32'(err_len), 32'(m_el));
    check_eq("err_pad", 32'(err_pad), 32'(m_ep));
    check_eq("err_chk", 32'(err_chk), 32'(m_ec));
    check_eq("good_count", 32'(good_count), 32'(m_good));
    check_eq("bad_count", 32'(bad_count), 32'(m_bad));
  endtask

  task automatic run_items(input int n, input int gap_pct);
    item_t it;
    item_t none;
    int    gaps;
    none = '0;
    for (int k = 0; k < n && q.size() > 0; k++) begin
      gaps = 0;
      while (gaps < 4 && int'($urandom_range(99)) < gap_pct) begin
        step(1'b0, 8'($urandom), none);
        gaps++;
      end
      it = q.pop_front();
      step(1'b1, it.b, it);
    end
  endtask

  task automatic run_all(input int gap_pct);
    run_items(100000, gap_pct);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_pdata"}, 32'(payload_data), 32'h0);
    check_eq({tag, "_pvalid"}, 32'(payload_valid), 32'h0);
    check_eq({tag, "_plast"}, 32'(payload_last), 32'h0);
    check_eq({tag, "_done"}, 32'(frame_done), 32'h0);
    check_eq({tag, "_flags"}, 32'({frame_ok, err_len, err_pad, err_chk}), 32'h0);
    check_eq({tag, "_good"}, 32'(good_count), 32'h0);
    check_eq({tag, "_bad"}, 32'(bad_count), 32'h0);
  endtask

  task automatic clear_model();
    m_ok = 1'b0; m_el = 1'b0; m_ep = 1'b0; m_ec = 1'b0;
    m_good = 0;  m_bad = 0;
  endtask

  initial begin
    int len;
    int pidx;
    clear_model();
    reset_n    = 1'b0;
    valid      = 1'b0;
    frame_data = 8'h00;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Short frame: 4 payload bytes, 12 pad bytes, checksum 04.
    fixed_pl = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    build_frame(4, 8'h00, -1, 8'h00);
    run_all(0);
    check_eq("short_good", 32'(good_count), 32'd1);

    // Full frame, no pad.
    fixed_pl = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h01, 8'h02,
                 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
    build_frame(16, 8'h00, -1, 8'h00);
    run_all(0);
    check_eq("full_good", 32'(good_count), 32'd2);

    // Wrong checksum (05), then a bad pad byte with a consistent checksum.
    fixed_pl = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    build_frame(4, 8'h01, -1, 8'h00);
    run_all(0);
    check_eq("chkerr_bad", 32'(bad_count), 32'd1);
    fixed_pl = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    build_frame(4, 8'h00, 2, 8'h01);
    run_all(0);
    check_eq("paderr_flags", 32'({frame_ok, err_pad, err_chk}), 32'b010);

    // Illegal lengths followed by a good frame.
    build_frame(0, 8'h00, -1, 8'h00);
    build_frame(17, 8'h00, -1, 8'h00);
    build_frame(7, 8'h00, -1, 8'h00);
    run_all(0);

    // Leading junk, then a frame with an SFD byte inside the payload.
    q.push_back(item_t'({8'h00, 7'b0}));
    q.push_back(item_t'({8'h55, 7'b0}));
    q.push_back(item_t'({8'hAA, 7'b0}));
    fixed_pl = '{8'h12, SFD, 8'h34};
    build_frame(3, 8'h00, -1, 8'h00);
    run_all(0);

    // Back-to-back frames.
    build_frame(5, 8'h00, -1, 8'h00);
    build_frame(16, 8'h00, -1, 8'h00);
    run_all(0);

    // Randomized frames with junk and gaps.
    for (int f = 0; f < 40; f++) begin
      push_junk(int'($urandom_range(2)));
      len  = ($urandom_range(9) == 0) ? ((($urandom_range(1)) == 0) ? 0 : 17)
                                      : int'($urandom_range(1, MAX_LEN));
      pidx = ($urandom_range(3) == 0) ? int'($urandom_range(MIN_BODY - 1)) : -1;
      build_frame(len, ($urandom_range(4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                  pidx, 8'($urandom_range(1, 255)));
      run_all(30);
    end

    // Reset during payload abandons the frame.
    fixed_pl = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    build_frame(4, 8'h00, -1, 8'h00);
    run_items(4, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    q.delete();
    clear_model();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    fixed_pl = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    build_frame(4, 8'h00, -1, 8'h00);
    run_all(0);
    check_eq("after_reset_good", 32'(good_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/frame_depadder_checker.md
# frame_depadder_checker

Receive-side stage that sits directly downstream of the padded frame generator and consumes its `frame_data`/`valid` byte stream. It locks onto the start-of-frame delimiter and checks the length byte. It forwards exactly LEN payload bytes, discards and verifies the zero padding, and checks the XOR checksum. Each frame ends with a one-cycle verdict pulse, error flags, and saturating good/bad frame counters.

## Interface
- `SFD`, 8'hD5: start-of-frame delimiter byte.
- `MIN_BODY`, 16: minimum payload+pad byte count; shorter payloads are zero-padded up to this.
- `MAX_LEN`, 16: largest legal LEN value; legal range is 1..MAX_LEN.
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `frame_data`  in  8  incoming byte; sampled only when `valid`=1.
- `valid`  in  1  byte qualifier; low cycles are gaps and hold all state.
- `payload_data`  out  8  forwarded payload byte.
- `payload_valid`  out  1  qualifies `payload_data`, one cycle per payload byte.
- `payload_last`  out  1  high with the LEN-th payload byte.
- `frame_done`  out  1  one-cycle pulse at end of every frame, good or bad.
- `frame_ok`  out  1  verdict; valid while `frame_done`=1, held until next `frame_done`.
- `err_len`, `err_pad`, `err_chk`  out  1 each  cause flags; updated with `frame_done`, held until next `frame_done`.
- `good_count`, `bad_count`  out  16 each  frame counters; saturate at 16'hFFFF.

## Operation
- States: IDLE, LEN, PAYLOAD, PAD, CHK. Only accepted bytes (`valid`=1) advance state or counters.
- IDLE:
  - byte == SFD → LEN; all other bytes are dropped silently.
  - Clear the per-frame xor accumulator, pad_err flag and byte counter on entry to LEN.
- LEN:
  - Byte is 0 or > MAX_LEN → end frame bad with `err_len`=1, return to IDLE.
  - Otherwise store len, set xor = byte, go to PAYLOAD.
- PAYLOAD:
  - Each byte is forwarded, XORed into the accumulator, and increments cnt.
  - Once cnt reaches len: go to PAD if len < MIN_BODY, else go to CHK.
  - A byte equal to SFD inside the payload is plain data.
- PAD:
  - Expect exactly MIN_BODY − len bytes; each is XORed into the accumulator.
  - Any nonzero byte sets pad_err. Counting continues to the end; there is no early abort.
  - After the last pad byte → CHK.
- CHK:
  - Next accepted byte is the checksum.
  - err_chk = (byte != xor); frame_ok = !pad_err && !err_chk.
  - Pulse `frame_done`, go to IDLE.
- Counters: on each `frame_done`, increment good_count if frame_ok, else bad_count. Hold at 16'hFFFF.
- Checksum = XOR of the LEN byte, all payload bytes, and all pad bytes. SFD is excluded.
- Payload is forwarded before the verdict. Consumers must qualify it with `frame_ok`.

## Timing
- Reset (`reset_n`=0, asynchronous): state=IDLE. All outputs 0: payload_data 8'h00, payload_valid, payload_last, frame_done, frame_ok, err_* flags, both counters.
- Reset mid-frame abandons the frame immediately. No `frame_done` and no counter update for it.
- Payload latency: a byte accepted at edge k appears on `payload_*` for exactly the cycle after edge k. `payload_valid` is 0 otherwise.
- `frame_done`/`frame_ok`/`err_*`/counter updates are registered. They are visible in the cycle after the edge that accepts the CHK byte, or the bad LEN byte.
- `frame_done` is high exactly one cycle. Back-to-back frames are legal: an SFD on the cycle after CHK is accepted.
- Gaps (`valid`=0) of any length in any state: no state change, no outputs other than pulses clearing.
- Minimum frame: 1+1+MIN_BODY+1 = 19 accepted bytes at defaults.

## Test plan
- **Short frame.** Send D5,04,AA,BB,CC,DD, 12×00, 04 with valid held high.
  - AA..DD appear one cycle after acceptance; payload_last is high with DD.
  - frame_done with frame_ok=1; good_count=1.
- **Full frame, no pad.** Send D5,10, then AA,BB,CC,DD,EE,FF,01..0A, then 0A.
  - 16 payload bytes forwarded; no PAD state.
  - frame_ok=1; good_count increments.
- **Checksum and pad errors.**
  - Short frame with checksum 05 → frame_ok=0, err_chk=1, bad_count=1.
  - Short frame with the 3rd pad byte = 01 and checksum corrected to 05 → err_pad=1, err_chk=0, frame_ok=0.
- **Length errors.**
  - D5,00 → frame_done after the LEN byte, err_len=1, no payload_valid.
  - D5,11 → same result.
  - A subsequent good frame is accepted normally.
- **Gaps and junk.**
  - Leading bytes 00,55,AA before the SFD are ignored.
  - Random valid=0 gaps inside a frame give identical payload and verdict.
  - Two frames back-to-back give two frame_done pulses.
- **Reset mid-frame.**
  - Drop reset_n during PAYLOAD → all outputs 0 asynchronously; counters 0.
  - After release, a clean short frame gives good_count=1.
